// File: rtl/alu_pkg.sv
// Shared widths, instruction field positions and slot payload for the alu path.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned REG_AW  = $clog2(NREGS);
  localparam int unsigned INSTR_W = 32;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  typedef logic [REG_AW-1:0]  reg_addr_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    instr_t instruction;
    data_t  reg_a;
    data_t  reg_b;
  } operand_slot_t;

  function automatic reg_addr_t rs_field(input instr_t instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic reg_addr_t rt_field(input instr_t instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file: register 0 hardwired to zero, two write-first read ports.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a_c,
  output logic [DATA_W-1:0] rd_data_b_c
);

  data_t regs_q [NREGS];
  data_t regs_d [NREGS];
  logic  wr_live_c;

  always_comb begin
    wr_live_c = wr_en && (wr_addr != '0);
    regs_d    = regs_q;
    if (wr_live_c) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // A same-cycle write to the read address wins over the stored value.
  always_comb begin
    rd_data_a_c = regs_q[rd_addr_a];
    if (rd_addr_a == '0) begin
      rd_data_a_c = '0;
    end else if (wr_live_c && (wr_addr == rd_addr_a)) begin
      rd_data_a_c = wr_data;
    end

    rd_data_b_c = regs_q[rd_addr_b];
    if (rd_addr_b == '0) begin
      rd_data_b_c = '0;
    end else if (wr_live_c && (wr_addr == rd_addr_b)) begin
      rd_data_b_c = wr_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch stage feeding the alu: one registered slot with valid/ready,
// write-first operand read and writeback coherence while the slot is stalled.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [DATA_W-1:0]  out_reg_a,
  output logic [DATA_W-1:0]  out_reg_b
);

  operand_slot_t slot_q, slot_d;
  logic          valid_q, valid_d;
  data_t         rd_a_c, rd_b_c;
  reg_addr_t     in_rs_c, in_rt_c, slot_rs_c, slot_rt_c;
  logic          accept_c, wb_live_c;

  assign in_rs_c   = rs_field(in_instruction);
  assign in_rt_c   = rt_field(in_instruction);
  assign slot_rs_c = rs_field(slot_q.instruction);
  assign slot_rt_c = rt_field(slot_q.instruction);

  alu_regfile u_regfile (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wb_en),
    .wr_addr     (wb_addr),
    .wr_data     (wb_data),
    .rd_addr_a   (in_rs_c),
    .rd_addr_b   (in_rt_c),
    .rd_data_a_c (rd_a_c),
    .rd_data_b_c (rd_b_c)
  );

  always_comb begin
    in_ready  = !valid_q || out_ready;
    accept_c  = in_valid && in_ready;
    wb_live_c = wb_en && (wb_addr != '0);
    valid_d   = valid_q;
    slot_d    = slot_q;

    if (accept_c) begin
      valid_d            = 1'b1;
      slot_d.instruction = in_instruction;
      slot_d.reg_a       = rd_a_c;
      slot_d.reg_b       = rd_b_c;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q && wb_live_c) begin
      // Stalled slot tracks writebacks so the alu never sees a stale operand.
      if (wb_addr == slot_rs_c) slot_d.reg_a = wb_data;
      if (wb_addr == slot_rt_c) slot_d.reg_b = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_instruction = slot_q.instruction;
  assign out_reg_a       = slot_q.reg_a;
  assign out_reg_b       = slot_q.reg_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic against a file/slot model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_en, out_valid, out_ready;
  logic [31:0] in_instruction, wb_data, out_instruction, out_reg_a, out_reg_b;
  logic [4:0]  wb_addr;

  int n_pass  = 0;
  int n_total = 0;

  // Model: architectural register contents and what the alu should currently see.
  logic [31:0] m_file [32];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0, m_a = '0, m_b = '0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_reg_a       (out_reg_a),
    .out_reg_b       (out_reg_b)
  );

  task automatic drive_idle();
    rst            = 1'b0;
    in_valid       = 1'b0;
    in_instruction = '0;
    wb_en          = 1'b0;
    wb_addr        = '0;
    wb_data        = '0;
    out_ready      = 1'b1;
  endtask

  // Advance one clock; the model reads operands from the file as it stands after
  // this cycle's writeback, and a stalled slot always mirrors that file.
  task automatic step();
    logic [31:0] nf [32];
    logic [4:0]  rs, rt;
    bit          fire;
    nf = m_file;
    if (rst) begin
      for (int i = 0; i < 32; i++) nf[i] = '0;
      m_valid = 1'b0; m_instr = '0; m_a = '0; m_b = '0;
    end else begin
      if (wb_en && wb_addr != 5'd0) nf[wb_addr] = wb_data;
      fire = in_valid && (!m_valid || out_ready);
      if (fire) begin
        rs = in_instruction[25:21];
        rt = in_instruction[20:16];
        m_valid = 1'b1; m_instr = in_instruction; m_a = nf[rs]; m_b = nf[rt];
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end else if (m_valid) begin
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        m_a = nf[rs]; m_b = nf[rt];
      end
    end
    @(posedge clk);
    #1;
    m_file = nf;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1; in_valid = 1'b1; in_instruction = $urandom;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = $urandom; out_ready = 1'b0;
    step();
    step();
    drive_idle();
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_instruction !== 32'd0) $display("FAIL reset_instr got %h want 0", out_instruction); else n_pass++;
    n_total++; if (out_reg_a !== 32'd0) $display("FAIL reset_reg_a got %h want 0", out_reg_a); else n_pass++;
    n_total++; if (out_reg_b !== 32'd0) $display("FAIL reset_reg_b got %h want 0", out_reg_b); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
    out_ready = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready_no_out_ready got %0b want 1", in_ready); else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_basic();
    drive_idle();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd10;
    step();
    wb_addr = 5'd2; wb_data = 32'hFFFF_FFF6;
    step();
    wb_en = 1'b0; in_valid = 1'b1; in_instruction = 32'h0041_0820;
    step();
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_instruction !== 32'h0041_0820) $display("FAIL basic_instr got %h want 00410820", out_instruction); else n_pass++;
    n_total++; if (out_reg_a !== 32'hFFFF_FFF6) $display("FAIL basic_reg_a got %h want fffffff6", out_reg_a); else n_pass++;
    n_total++; if (out_reg_b !== 32'd10) $display("FAIL basic_reg_b got %h want 0000000a", out_reg_b); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_drain_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_instruction !== 32'h0041_0820) $display("FAIL basic_drain_hold got %h want 00410820", out_instruction); else n_pass++;
  endtask

  task automatic test_reg_zero();
    drive_idle();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    step();
    in_valid = 1'b1; in_instruction = 32'h0001_4020;
    step();
    drive_idle();
    n_total++; if (out_reg_a !== 32'd0) $display("FAIL zero_reg_a got %h want 0", out_reg_a); else n_pass++;
    n_total++; if (out_reg_b !== 32'd10) $display("FAIL zero_reg_b got %h want 0000000a", out_reg_b); else n_pass++;
    step();
  endtask

  task automatic test_bypass();
    drive_idle();
    in_valid = 1'b1; in_instruction = 32'h0041_0820;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd7;
    step();
    n_total++; if (out_reg_a !== 32'd7) $display("FAIL bypass_reg_a got %h want 00000007", out_reg_a); else n_pass++;
    n_total++; if (out_reg_b !== 32'd10) $display("FAIL bypass_reg_b got %h want 0000000a", out_reg_b); else n_pass++;
  endtask

  // Expects the slot to hold 0x00410820 with a=7, b=10 on entry.
  task automatic test_stall();
    drive_idle();
    out_ready = 1'b0; in_valid = 1'b1; in_instruction = 32'h0022_1820;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %0b want 0", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instruction !== 32'h0041_0820 ||
          out_reg_a !== 32'd7 || out_reg_b !== 32'd10)
        $display("FAIL stall_hold cyc %0d got rdy=%0b v=%0b i=%h a=%h b=%h want rdy=0 v=1 i=00410820 a=7 b=a",
                 i, in_ready, out_valid, out_instruction, out_reg_a, out_reg_b);
      else n_pass++;
    end
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd99;
    step();
    wb_en = 1'b0;
    n_total++; if (out_reg_b !== 32'd99) $display("FAIL stall_wb_reg_b got %h want 00000063", out_reg_b); else n_pass++;
    n_total++; if (out_reg_a !== 32'd7) $display("FAIL stall_wb_reg_a got %h want 00000007", out_reg_a); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL drain_in_ready got %0b want 1", in_ready); else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b1 || out_instruction !== 32'h0022_1820 || out_reg_a !== 32'd99 || out_reg_b !== 32'd7)
      $display("FAIL drain_accept got v=%0b i=%h a=%h b=%h want v=1 i=00221820 a=63 b=7",
               out_valid, out_instruction, out_reg_a, out_reg_b);
    else n_pass++;
    // rs == rt: one writeback must refresh both operands of a stalled slot.
    in_instruction = 32'h0063_1820;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    step();
    drive_idle();
    n_total++;
    if (out_reg_a !== 32'h55 || out_reg_b !== 32'h55)
      $display("FAIL stall_same_reg got a=%h b=%h want a=55 b=55", out_reg_a, out_reg_b);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    drive_idle();
    for (int i = 0; i < 4; i++) q.push_back($urandom);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instruction = q[i];
      wb_en = 1'b1; wb_addr = 5'($urandom_range(31)); wb_data = $urandom;
      step();
      n_total++;
      if (out_valid !== 1'b1 || out_instruction !== q[i] || out_reg_a !== m_a || out_reg_b !== m_b)
        $display("FAIL b2b %0d got v=%0b i=%h a=%h b=%h want v=1 i=%h a=%h b=%h",
                 i, out_valid, out_instruction, out_reg_a, out_reg_b, q[i], m_a, m_b);
      else n_pass++;
    end
    drive_idle();
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_end_valid got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid       = ($urandom_range(9) < 7);
      in_instruction = $urandom;
      out_ready      = ($urandom_range(9) < 6);
      wb_en          = ($urandom_range(1) == 1);
      wb_addr        = ($urandom_range(3) == 0) ? in_instruction[25:21] : 5'($urandom_range(7));
      wb_data        = $urandom;
      #1;
      n_total++;
      if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rand_in_ready cyc %0d got %0b want %0b", c, in_ready, !m_valid || out_ready);
      else n_pass++;
      step();
      n_total++;
      if (out_valid !== m_valid || out_instruction !== m_instr || out_reg_a !== m_a || out_reg_b !== m_b)
        $display("FAIL rand_slot cyc %0d got v=%0b i=%h a=%h b=%h want v=%0b i=%h a=%h b=%h",
                 c, out_valid, out_instruction, out_reg_a, out_reg_b, m_valid, m_instr, m_a, m_b);
      else n_pass++;
    end
    drive_idle();
    step();
  endtask

  task automatic test_mid_reset();
    drive_idle();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hABCD;
    step();
    wb_en = 1'b0; in_valid = 1'b1; in_instruction = 32'h0022_1820; out_ready = 1'b0;
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL mid_reset_pre_valid got %0b want 1", out_valid); else n_pass++;
    rst = 1'b1;
    step();
    n_total++;
    if (out_valid !== 1'b0 || out_instruction !== 32'd0 || out_reg_a !== 32'd0 || out_reg_b !== 32'd0)
      $display("FAIL mid_reset_slot got v=%0b i=%h a=%h b=%h want all 0",
               out_valid, out_instruction, out_reg_a, out_reg_b);
    else n_pass++;
    rst = 1'b0; out_ready = 1'b1;
    step();
    n_total++;
    if (out_valid !== 1'b1 || out_reg_a !== 32'd0 || out_reg_b !== 32'd0)
      $display("FAIL mid_reset_file got v=%0b a=%h b=%h want v=1 a=0 b=0", out_valid, out_reg_a, out_reg_b);
    else n_pass++;
    drive_idle();
    step();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_reg_zero();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the alu block: accepts a 32-bit MIPS-format instruction and reads its rs/rt operands from an internal 32x32 register file.
- Presents instruction, regA and regB to the alu through one registered output slot with a valid/ready handshake.
- Has a writeback port so results coming back from the alu path update the file; same-cycle write/read and stalled-slot hazards are resolved internally.

Parameters:
- DATA_W, 32, operand and register width
- NREGS, 32, register file depth (address width = log2(NREGS) = 5)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_instruction  in  32  instruction word; rs = [25:21], rt = [20:16]
- wb_en  in  1  register write enable
- wb_addr  in  5  register write address
- wb_data  in  DATA_W  register write data
- out_valid  out  1  slot holds a valid instruction for the alu
- out_ready  in  1  alu side consumes the slot this cycle
- out_instruction  out  32  registered instruction, drives alu instruction
- out_reg_a  out  DATA_W  value of rs, drives alu regA
- out_reg_b  out  DATA_W  value of rt, drives alu regB

Behaviour:
- Reset (synchronous, active-high):
  - out_valid = 0.
  - out_instruction, out_reg_a and out_reg_b = 0.
  - All register file entries = 0.
  - Reset mid-transfer drops the held instruction with no output.
- Register file:
  - Register 0 always reads 0; writes to address 0 are ignored.
  - On wb_en with wb_addr != 0, the write lands at the clock edge.
- Operand read is write-first. If wb_en=1, wb_addr != 0 and wb_addr equals rs (or rt) in the same cycle, the captured operand is wb_data, not the stale file value.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and has no dependence on in_valid.
  - A transfer occurs when in_valid && in_ready. On transfer: capture instruction and operands into the slot, and set out_valid = 1 next cycle.
  - When out_valid && out_ready with no new transfer: out_valid = 0 next cycle. The data outputs hold their last value.
  - Back-to-back transfers sustain 1 instruction per cycle.
  - Latency is 1 cycle from accepted input to out_valid.
- Stall coherence:
  - While out_valid=1 and out_ready=0, the slot's outputs are held stable.
  - Exception: a writeback with wb_addr != 0 matching the slot's rs (or rt) field replaces out_reg_a (or out_reg_b) with wb_data at that edge.
  - If rs == rt, both operands update.
- Simultaneous slot drain and new accept: the new instruction overwrites the slot, and operands take the write-first values.
- No arithmetic is performed here. The slot fields are kept at 32 bits so the alu op/funct decode sees the full word.

Decomposition:
- Shared package alu_pkg:
  - DATA_W
  - register address width
  - field position constants RS_MSB/RS_LSB and RT_MSB/RT_LSB, also reused by alu decode
- One sub-module: alu_regfile. It holds the 32-entry storage, the register-0 hardwiring and the write-first read on two read ports.
- Handshake, slot register and stall-coherence logic stay in alu_operand_stage.

Test Plan:
- Reset then idle:
  - Assert rst 2 cycles with in_valid=1.
  - Required: out_valid=0, all outputs 0, in_ready=1 after reset.
- Basic fetch:
  - Write $1=10 and $2=0xFFFFFFF6, then issue 0x00410820 with out_ready=1.
  - Required next cycle: out_valid=1, out_reg_a=0xFFFFFFF6 (-10), out_reg_b=10, out_instruction=0x00410820.
- Register zero:
  - wb_en=1 with wb_addr=0 and data 0x1234, then issue 0x00014020.
  - Required: out_reg_a=0, out_reg_b=$1.
- Write-first bypass:
  - In the same cycle, issue 0x00410820 while wb writes $2=7.
  - Required: out_reg_a=7.
- Stall:
  - Hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0, outputs stable.
  - Then write $1=99 during the stall. Required: out_reg_b becomes 99 next cycle.
  - Then raise out_ready. Required: the slot drains and the next instruction enters the same cycle.
- Throughput and mid-stream reset:
  - Stream 4 instructions with out_ready=1. Required: 4 consecutive out_valid cycles in order.
  - Assert rst with the slot valid. Required: out_valid=0 next cycle and the file cleared.
